// File: rtl/proc_sequencer_pkg.sv
// Shared types for the instruction sequencer: opcodes, FSM states
// and the 12-bit instruction word layout {op, dr, sr1, sr2}.
package proc_pkg;

  localparam int INSTR_W = 12;
  localparam int OP_LSB  = 9;
  localparam int DR_LSB  = 6;
  localparam int SR1_LSB = 3;
  localparam int SR2_LSB = 0;

  typedef logic [2:0] op_t;
  typedef logic [2:0] reg_t;

  localparam op_t OP_NOP   = 3'b000;
  localparam op_t OP_LOAD  = 3'b001;
  localparam op_t OP_ADD   = 3'b010;
  localparam op_t OP_MUL   = 3'b011;
  localparam op_t OP_JMP   = 3'b100;
  localparam op_t OP_CMP   = 3'b101;
  localparam op_t OP_STORE = 3'b110;
  localparam op_t OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_STEPWAIT,
    S_HALT
  } state_t;

  // Packed so that field bit positions match the *_LSB constants.
  typedef struct packed {
    op_t  op;
    reg_t dr;
    reg_t sr1;
    reg_t sr2;
  } instr_t;

endpackage

// File: rtl/proc_sequencer_if.sv
// Datapath issue channel: valid/ready plus decoded instruction fields.
// master = sequencer (drives valid/fields), slave = datapath (drives ready).
interface proc_sequencer_if
  import proc_pkg::*;
();

  logic dp_valid;
  op_t  dp_op;
  reg_t dp_dr;
  reg_t dp_sr1;
  reg_t dp_sr2;
  logic dp_ready;

  modport master (
    output dp_valid, dp_op, dp_dr, dp_sr1, dp_sr2,
    input  dp_ready
  );

  modport slave (
    input  dp_valid, dp_op, dp_dr, dp_sr1, dp_sr2,
    output dp_ready
  );

endinterface

// File: rtl/proc_sequencer_seq_decode.sv
// Opcode classifier: issue to datapath, jump, or halt.
// Ports: op in; is_issue/is_jmp/is_halt out (NOP raises none).
module seq_decode
  import proc_pkg::*;
(
  input  op_t  op,
  output logic is_issue,
  output logic is_jmp,
  output logic is_halt
);

  always_comb begin
    is_issue = 1'b0;
    is_jmp   = 1'b0;
    is_halt  = 1'b0;
    unique case (1'b1)
      (op == OP_NOP):  ;
      (op == OP_JMP):  is_jmp  = 1'b1;
      (op == OP_HALT): is_halt = 1'b1;
      default:         is_issue = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetch from program memory, decode, issue
// to the datapath. Ports: clock/reset, start/step controls,
// pmem_addr/pmem_rdata, dp (issue channel), busy/halted/pc/retired.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  output logic [PC_W-1:0]  pmem_addr,
  input  logic [11:0]      pmem_rdata,
  proc_sequencer_if.master dp,
  output logic             busy,
  output logic             halted,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired
);

  state_t           st;
  instr_t           ir;
  instr_t           iw;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [PC_W-1:0]  jmp_tgt;
  state_t           rt_st;
  logic             is_issue;
  logic             is_jmp;
  logic             is_halt;

  assign iw      = instr_t'(pmem_rdata);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign jmp_tgt = PC_W'({iw.sr1, iw.sr2});
  assign rt_st   = step_mode ? S_STEPWAIT : S_FETCH;

  seq_decode u_dec (
    .op       (iw.op),
    .is_issue (is_issue),
    .is_jmp   (is_jmp),
    .is_halt  (is_halt)
  );

  // pc only moves at retire, so it doubles as the fetch address.
  assign pmem_addr  = pc_q;
  assign pc         = pc_q;
  assign retired    = cnt_q;
  assign dp.dp_op   = ir.op;
  assign dp.dp_dr   = ir.dr;
  assign dp.dp_sr1  = ir.sr1;
  assign dp.dp_sr2  = ir.sr2;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      st          <= S_IDLE;
      ir          <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      dp.dp_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE, S_HALT: begin
          if (start) begin
            st     <= S_FETCH;
            pc_q   <= '0;
            cnt_q  <= '0;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: st <= S_DECODE;
        S_DECODE: begin
          ir <= iw;
          if (is_halt) begin
            st     <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (is_issue) begin
            st          <= S_ISSUE;
            dp.dp_valid <= 1'b1;
          end else begin
            st    <= rt_st;
            cnt_q <= cnt_inc;
            pc_q  <= is_jmp ? jmp_tgt : pc_q + 1'b1;
          end
        end
        S_ISSUE: begin
          if (dp.dp_ready) begin
            st          <= rt_st;
            dp.dp_valid <= 1'b0;
            cnt_q       <= cnt_inc;
            pc_q        <= pc_q + 1'b1;
          end
        end
        S_STEPWAIT: if (step) st <= S_FETCH;
        default: begin
          st   <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: directed sequences, a
// vector table and random programs against an instruction-level model.
module tb_proc_sequencer;
  import proc_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [5:0]  pmem_addr;
  logic [11:0] pmem_rdata;
  logic        busy, halted;
  logic [5:0]  pc;
  logic [15:0] retired;
  logic        ready_man = 1'b1;
  logic        rnd_en = 1'b0;
  logic        rnd_bit = 1'b1;
  logic [11:0] mem [64];

  logic        s_start = 1'b0;
  logic [5:0]  s_addr;
  logic [11:0] s_rdata;
  logic        s_busy, s_halted;
  logic [5:0]  s_pc;
  logic [2:0]  s_retired;
  logic [11:0] s_mem [64];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [11:0] w;
    int          idx;
  } xfer_t;
  xfer_t       xq[$];
  logic [11:0] exp_q[$];

  typedef struct packed {
    logic [3:0][11:0] prog;
    int               ret;
    int               nx;
    int               pc;
  } vec_t;
  vec_t tbl[5];

  proc_sequencer_if dpi ();
  proc_sequencer_if sif ();

  assign dpi.dp_ready = rnd_en ? rnd_bit : ready_man;
  assign sif.dp_ready = 1'b1;

  proc_sequencer dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .step_mode  (step_mode),
    .step       (step),
    .pmem_addr  (pmem_addr),
    .pmem_rdata (pmem_rdata),
    .dp         (dpi.master),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .retired    (retired)
  );

  proc_sequencer #(.PC_W(6), .CNT_W(3)) u_sat (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (s_start),
    .step_mode  (1'b0),
    .step       (1'b0),
    .pmem_addr  (s_addr),
    .pmem_rdata (s_rdata),
    .dp         (sif.master),
    .busy       (s_busy),
    .halted     (s_halted),
    .pc         (s_pc),
    .retired    (s_retired)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    pmem_rdata <= mem[pmem_addr];
    s_rdata    <= s_mem[s_addr];
    cyc        <= cyc + 1;
  end

  always @(posedge CLOCK_50) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [11:0] mk(int op, int dr, int s1, int s2);
    return {3'(op), 3'(dr), 3'(s1), 3'(s2)};
  endfunction

  function automatic vec_t mkv(logic [11:0] w0, logic [11:0] w1,
                               logic [11:0] w2, logic [11:0] w3,
                               int r, int nx, int p);
    vec_t v;
    v.prog = {w3, w2, w1, w0};
    v.ret  = r;
    v.nx   = nx;
    v.pc   = p;
    return v;
  endfunction

  // Channel monitor: log transfers, count stalls, check stability.
  logic        pv = 1'b0, pr = 1'b0;
  logic [11:0] pf = '0;
  always @(negedge CLOCK_50) begin
    logic [11:0] f;
    f = {dpi.dp_op, dpi.dp_dr, dpi.dp_sr1, dpi.dp_sr2};
    if (dpi.dp_valid && dpi.dp_ready)
      xq.push_back('{w: f, idx: cyc - start_cyc + 1});
    if (dpi.dp_valid && !dpi.dp_ready) stall_cnt++;
    if (resetn && pv && !pr && dpi.dp_valid) chk("stable", f, pf);
    pv = dpi.dp_valid;
    pr = dpi.dp_ready;
    pf = f;
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic wait_halt(int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick(1);
      n++;
    end
    chk("halt_timeout", halted, 1);
  endtask

  task automatic fill(logic [11:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  // Walk the program instruction by instruction.
  task automatic model(output int r, output int p);
    int a = 0;
    int g = 0;
    r = 0;
    exp_q.delete();
    while (g < 200) begin
      logic [11:0] w;
      int          op;
      w  = mem[a];
      op = int'(w[11:9]);
      g++;
      if (op == 7) break;
      r++;
      if (op == 4) a = int'(w[5:0]);
      else begin
        if (op != 0) exp_q.push_back(w);
        a = (a + 1) % 64;
      end
    end
    p = a;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int r, p;
    fill(mk(7, 0, 0, 0));
    for (int i = 0; i < 64; i++) s_mem[i] = (i < 9) ? 12'h000 : mk(7, 0, 0, 0);

    // Reset state
    #3;
    chk("rst_valid", dpi.dp_valid, 0);
    chk("rst_op", dpi.dp_op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pmem", pmem_addr, 0);
    chk("rst_ret", retired, 0);
    do_reset();

    // Basic timing: LOAD, ADD, HALT with ready high
    mem[0] = mk(1, 1, 0, 0);
    mem[1] = mk(2, 2, 1, 1);
    mem[2] = mk(7, 0, 0, 0);
    xq.delete();
    pulse_start();
    chk("busy_run", busy, 1);
    wait_halt(50);
    chk("t1_nx", xq.size(), 2);
    if (xq.size() >= 2) begin
      chk("t1_cyc0", xq[0].idx, 3);
      chk("t1_op0", xq[0].w[11:9], 1);
      chk("t1_cyc1", xq[1].idx, 6);
      chk("t1_op1", xq[1].w[11:9], 2);
    end
    chk("t1_ret", retired, 2);
    chk("t1_busy", busy, 0);
    chk("t1_pc", pc, 2);

    // Stall ADD for 5 cycles
    mem[1] = mk(2, 3, 4, 5);
    xq.delete();
    stall_cnt = 0;
    pulse_start();
    chk("t2_clr", retired, 0);
    tick(3);
    ready_man = 1'b0;
    tick(7);
    chk("t2_mid_ret", retired, 1);
    chk("t2_mid_valid", dpi.dp_valid, 1);
    ready_man = 1'b1;
    wait_halt(20);
    chk("t2_stalls", stall_cnt, 5);
    chk("t2_nx", xq.size(), 2);
    if (xq.size() >= 2) chk("t2_fields", xq[1].w, mk(2, 3, 4, 5));
    chk("t2_ret", retired, 2);

    // Single-step mode
    mem[0] = 12'h000;
    mem[1] = 12'h000;
    step_mode = 1'b1;
    pulse_start();
    chk("t3_pc0", pc, 0);
    tick(2);
    chk("t3_pc1", pc, 1);
    chk("t3_ret1", retired, 1);
    tick(8);
    chk("t3_wait", retired, 1);
    step = 1'b1;
    start = 1'b1;
    tick(1);
    step = 1'b0;
    start = 1'b0;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(9);
    chk("t3_pc2", pc, 2);
    chk("t3_ret2", retired, 2);
    chk("t3_busy", busy, 1);
    chk("t3_nohalt", halted, 0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(4);
    chk("t3_halt", halted, 1);
    chk("t3_ret_end", retired, 2);
    step_mode = 1'b0;

    // JMP to 63, wrap to 0, start mid-loop ignored
    fill(12'h000);
    mem[0] = mk(4, 0, 7, 7);
    pulse_start();
    tick(2);
    chk("t4_pc63", pc, 63);
    tick(2);
    chk("t4_wrap", pc, 0);
    chk("t4_ret2", retired, 2);
    pulse_start();
    tick(1);
    chk("t4_nostart", retired, 3);
    tick(20);
    chk("t4_ret13", retired, 13);
    chk("t4_pc", pc, 63);

    // Asynchronous reset during a stalled issue
    do_reset();
    fill(mk(7, 0, 0, 0));
    mem[0] = mk(1, 2, 3, 4);
    ready_man = 1'b0;
    pulse_start();
    tick(2);
    chk("t5_valid", dpi.dp_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_drop", dpi.dp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pc", pc, 0);
    chk("t5_op", dpi.dp_op, 0);
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    ready_man = 1'b1;
    xq.delete();
    pulse_start();
    wait_halt(30);
    chk("t5_nx", xq.size(), 1);
    chk("t5_ret", retired, 1);

    // Vector table
    tbl[0] = mkv(mk(7,0,0,0), 0, 0, 0, 0, 0, 0);
    tbl[1] = mkv(0, 0, 0, mk(7,0,0,0), 3, 0, 3);
    tbl[2] = mkv(mk(5,1,2,3), mk(6,4,5,6), mk(3,7,7,7), mk(7,0,0,0), 3, 3, 3);
    tbl[3] = mkv(mk(4,0,0,3), mk(1,0,0,0), mk(1,0,0,0), mk(7,0,0,0), 1, 0, 3);
    tbl[4] = mkv(mk(2,1,1,1), mk(4,0,0,3), 0, mk(7,0,0,0), 2, 1, 3);
    foreach (tbl[i]) begin
      fill(mk(7, 0, 0, 0));
      for (int k = 0; k < 4; k++) mem[k] = tbl[i].prog[k];
      xq.delete();
      pulse_start();
      wait_halt(60);
      chk($sformatf("v%0d_ret", i), retired, tbl[i].ret);
      chk($sformatf("v%0d_nx", i), xq.size(), tbl[i].nx);
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    // Random programs with random ready
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 63; a++) begin
        int op, tg;
        op = $urandom_range(0, 7);
        if (op == 7 && $urandom_range(0, 9) != 0) op = 0;
        if (op == 4) begin
          tg = $urandom_range(a + 1, 63);
          mem[a] = mk(4, $urandom_range(0, 7), tg / 8, tg % 8);
        end else
          mem[a] = mk(op, $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7));
      end
      mem[63] = mk(7, 0, 0, 0);
      model(r, p);
      xq.delete();
      rnd_en = 1'b1;
      pulse_start();
      wait_halt(3000);
      rnd_en = 1'b0;
      chk("rnd_nx", xq.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < xq.size(); k++)
        chk($sformatf("rnd%0d_x%0d", t, k), xq[k].w, exp_q[k]);
      chk("rnd_ret", retired, r);
      chk("rnd_pc", pc, p);
    end

    // Counter saturation on the narrow-counter instance
    begin
      int n = 0;
      s_start = 1'b1;
      tick(1);
      s_start = 1'b0;
      while (!s_halted && n < 100) begin
        tick(1);
        n++;
      end
      chk("sat_halt", s_halted, 1);
      chk("sat_ret", s_retired, 7);
      chk("sat_pc", s_pc, 9);
      s_start = 1'b1;
      tick(1);
      s_start = 1'b0;
      chk("sat_clr", s_retired, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
Instruction sequencer for the 8x8-bit register-file / data-RAM datapath. It replaces manual instruction entry and execute presses.
- Fetches 12-bit instruction words {op[2:0], dr[2:0], sr1[2:0], sr2[2:0]} from a program memory.
- Decodes each word and issues it to the datapath over a valid/ready handshake.
- Supports free-run and single-step modes, unconditional jump and halt.
- Sits between the board controls and the datapath execute port.

Parameters:
PC_W, 6, program counter width; program memory depth is 2**PC_W words.
CNT_W, 16, width of the retired-instruction counter.

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse: clear PC and counter, begin execution.
step_mode  in  1  1 = pause after every retired instruction.
step  in  1  one-cycle pulse: resume from a step pause.
pmem_addr  out  PC_W  program memory read address.
pmem_rdata  in  12  instruction word; valid exactly 1 cycle after pmem_addr is driven.
dp_valid  out  1  datapath issue request.
dp_op  out  3  opcode to datapath.
dp_dr  out  3  destination field.
dp_sr1  out  3  source 1 field.
dp_sr2  out  3  source 2 field.
dp_ready  in  1  datapath accepts or completes the current instruction.
busy  out  1  high in any state except IDLE and HALT.
halted  out  1  high in HALT.
pc  out  PC_W  address of the instruction currently in flight.
retired  out  CNT_W  count of retired instructions; saturating.

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE; pc=0; retired=0.
  - dp_valid=0; dp_op, dp_dr, dp_sr1, dp_sr2 = 0; pmem_addr=0.
  - busy=0; halted=0.
  - An issue in progress is abandoned and dp_valid drops immediately.
- States:
  - IDLE → FETCH on start.
  - FETCH: pmem_addr=pc; next state DECODE.
  - DECODE: latch pmem_rdata into the instruction register, then dispatch on opcode:
    - 000 NOP: retire without issue.
    - 100 JMP: pc ← {sr1,sr2} zero-extended or truncated to PC_W; retire without issue.
    - 111 HALT: go to HALT; not counted as retired.
    - 001 LOAD, 010 ADD, 011 MUL, 101 CMP, 110 STORE: go to ISSUE.
  - ISSUE:
    - dp_valid=1 with fields from the instruction register.
    - Fields stay stable while dp_valid=1 and dp_ready=0.
    - Transfer happens on the first cycle with dp_valid & dp_ready, including the first ISSUE cycle; that transfer is the retire.
  - STEPWAIT: entered on retire when step_mode=1; → FETCH on step.
  - HALT: sticky; start → clear PC and counter → FETCH.
- Retire:
  - retired increments by 1 and saturates at all-ones.
  - pc ← pc+1, wrapping from 2**PC_W-1 to 0. JMP instead loads its target.
  - Next state is FETCH if step_mode=0, otherwise STEPWAIT.
- Minimum latency per instruction:
  - Issued instruction with dp_ready already high: 3 cycles (FETCH, DECODE, ISSUE).
  - NOP/JMP: 2 cycles.
- Ignored inputs:
  - start in FETCH, DECODE, ISSUE or STEPWAIT is ignored; there is no restart mid-program.
  - step outside STEPWAIT is ignored; it is not queued.
  - step and start arriving together in STEPWAIT: step wins.
- step_mode is sampled only at retire.
- dp_valid is deasserted in the cycle after the transfer.
- The pc output equals the latched fetch address until retire.

Decomposition:
- Shared package proc_pkg:
  - Opcode constants OP_NOP=000, OP_LOAD=001, OP_ADD=010, OP_MUL=011, OP_JMP=100, OP_CMP=101, OP_STORE=110, OP_HALT=111.
  - State encoding IDLE, FETCH, DECODE, ISSUE, STEPWAIT, HALT.
  - Instruction field bit positions.
- One sub-module, seq_decode: combinational opcode classification producing is_issue, is_jmp, is_halt. Everything else stays in proc_sequencer.

Test Plan:
- Reset then start, dp_ready tied 1, program [LOAD 1,0,0; ADD 2,1,1; HALT] → dp_valid pulses at cycles 3 and 6 after start with op 001 then 010; halted=1; retired=2; busy=0.
- dp_ready held low 5 cycles during ADD → dp_valid and fields stable all 5 cycles; single transfer; retired increments once.
- step_mode=1, program [NOP; NOP; HALT]; step pulses spaced 10 cycles; extra step in FETCH → exactly one instruction retired per accepted step; extra step ignored; pc sequence 0, 1, 2.
- Program at word 0 = JMP to 0x3F, word 63 = NOP, word 0 reached again (PC_W=6) → pc wraps 63 to 0 and the loop repeats; start mid-loop ignored.
- resetn low during ISSUE with dp_ready=0 → dp_valid=0 in the same cycle with no clock edge; all outputs return to reset values; start after release executes from pc=0.
- Force retired to 0xFFFE, retire 3 NOPs → retired reads 0xFFFF; a start from HALT clears it to 0.
